// File: rtl/sr_link_pkg.sv
// Shared types and sizing for the 3-wire LED shift-register link receiver.
package sr_link_pkg;

  localparam int SR_FRAME_WIDTH = 12;
  localparam int SR_SYNC_STAGES = 2;

  typedef enum logic {
    HUNT    = 1'b0,
    ALIGNED = 1'b1
  } rx_state_t;

  // Counter must hold 0..WIDTH+1 so an over-long frame stays distinguishable from a good one.
  function automatic int sr_cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  localparam int SR_CNT_W = sr_cnt_width(SR_FRAME_WIDTH);

endpackage

// File: rtl/sr_edge_sync.sv
// Synchroniser plus rise detector for one asynchronous link input.
// Define SR_DEGLITCH_EN to insert a 3-sample majority filter ahead of edge detection.
module sr_edge_sync
  import sr_link_pkg::*;
#(
  parameter int SYNC_STAGES = SR_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
    end
  end

`ifdef SR_DEGLITCH_EN
  logic [1:0] hist;
  logic       filt;

  // Registered majority of the current and two previous samples: single-cycle pulses vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync[SYNC_STAGES-1]};
      filt <= (sync[SYNC_STAGES-1] & hist[0]) |
              (sync[SYNC_STAGES-1] & hist[1]) |
              (hist[0] & hist[1]);
    end
  end

  assign level = filt;
`else
  assign level = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b0;
    end else begin
      level_d <= level;
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/sr_frame_receiver.sv
// Receive end of the SR_CK/SR_Q/SR_LATCH link: deserialises MSB-first frames into a word.
// Optional input deglitching is enabled by defining SR_DEGLITCH_EN.
module sr_frame_receiver
  import sr_link_pkg::*;
#(
  parameter int WIDTH       = SR_FRAME_WIDTH,
  parameter int SYNC_STAGES = SR_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sr_ck,
  input  logic             sr_q,
  input  logic             sr_latch,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  output logic             frame_err,
  output logic             aligned
);

  localparam int            CW       = sr_cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  logic ck_rise;
  logic q_lvl;
  logic latch_rise;

  // CK and Q share identical synchroniser depth so Q is stable when the CK rise is seen.
  sr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sr_ck),
    .level (),
    .rise  (ck_rise)
  );

  sr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_q_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sr_q),
    .level (q_lvl),
    .rise  ()
  );

  sr_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sr_latch),
    .level (),
    .rise  (latch_rise)
  );

  rx_state_t state;
  rx_state_t state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: defaulting every always_comb output first keeps the block free of inferred latches.
  always_comb begin
    state_nxt = state;
    if (state == HUNT && latch_rise) begin
      state_nxt = ALIGNED;
    end
  end

  always_comb begin
    aligned = (state == ALIGNED);
  end

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_post;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    cnt_post;

  // Post-shift view: a CK rise coinciding with the latch rise still belongs to the latched frame.
  always_comb begin
    shreg_post = shreg;
    cnt_post   = bit_cnt;
    if (ck_rise) begin
      shreg_post = {shreg[WIDTH-2:0], q_lvl};
      if (bit_cnt != CNT_SAT) begin
        cnt_post = bit_cnt + CW'(1);
      end
    end
  end

  // NOTE: the shift register is reset explicitly so DATA can never expose power-up garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      shreg      <= shreg_post;
      bit_cnt    <= latch_rise ? '0 : cnt_post;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (latch_rise && state == ALIGNED) begin
        if (cnt_post == CNT_FULL) begin
          data       <= shreg_post;
          data_valid <= 1'b1;
        end else begin
          frame_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_frame_receiver.sv
// Randomised scoreboard bench for sr_frame_receiver; glitch test runs when SR_DEGLITCH_EN is defined.
module tb_sr_frame_receiver;
  import sr_link_pkg::*;

  localparam int W  = SR_FRAME_WIDTH;
  localparam int SS = SR_SYNC_STAGES;
`ifdef SR_DEGLITCH_EN
  localparam int LAT = SS + 3;
`else
  localparam int LAT = SS + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sr_ck;
  logic         sr_q;
  logic         sr_latch;
  logic [W-1:0] data;
  logic         data_valid;
  logic         frame_err;
  logic         aligned;

  sr_frame_receiver #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sr_ck      (sr_ck),
    .sr_q       (sr_q),
    .sr_latch   (sr_latch),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .aligned    (aligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_err;
    logic [W-1:0] val;
    int           due;
  } exp_t;

  exp_t sb[$];

  // Reference model: link-level view of frames as lists of received bits.
  bit           m_aligned = 1'b0;
  logic [W-1:0] m_held    = '0;
  bit           fbits[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_latch(input int at);
    logic [W-1:0] v;
    if (!m_aligned) begin
      m_aligned = 1'b1;
    end else if (fbits.size() == W) begin
      v = '0;
      foreach (fbits[i]) v = {v[W-2:0], fbits[i]};
      m_held = v;
      sb.push_back('{1'b0, v, at + LAT});
    end else begin
      sb.push_back('{1'b1, m_held, at + LAT});
    end
    fbits.delete();
  endtask

  task automatic send_bit(input bit b);
    sr_q = b;
    tick(2);
    sr_ck = 1'b1;
    fbits.push_back(b);
    tick(2);
    sr_ck = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_latch();
    sr_latch = 1'b1;
    model_latch(cyc);
    tick(2);
    sr_latch = 1'b0;
    tick(LAT + 4);
  endtask

  // Scoreboard monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (data_valid || frame_err)) begin
      check("pulse_exclusive", {63'd0, data_valid & frame_err}, 64'd0);
      check("pulse_expected", {63'd0, sb.size() > 0}, 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pulse_kind_err", {63'd0, frame_err}, {63'd0, e.is_err});
        check("pulse_data", {52'd0, data}, {52'd0, e.val});
        check("pulse_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    sr_ck    = 1'b0;
    sr_q     = 1'b0;
    sr_latch = 1'b0;
    tick(3);
    check("rst_data", {52'd0, data}, 64'd0);
    check("rst_valid", {63'd0, data_valid}, 64'd0);
    check("rst_err", {63'd0, frame_err}, 64'd0);
    check("rst_aligned", {63'd0, aligned}, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // First latch aligns only; second delivers the frame.
    send_word(32'hE2A, W);
    do_latch();
    check("aligned_after_first", {63'd0, aligned}, 64'd1);
    send_word(32'hE2A, W);
    do_latch();
    check("data_e2a", {52'd0, data}, 64'hE2A);

    // Short frame, then a good one.
    send_word(32'h2AA, W - 1);
    do_latch();
    check("data_held_short", {52'd0, data}, 64'hE2A);
    send_word(32'h555, W);
    do_latch();

    // Long frame, then an empty frame.
    send_word(32'h1ABC, W + 1);
    do_latch();
    do_latch();
    check("data_held_long", {52'd0, data}, 64'h555);

    // Reset mid-frame; the next frame is discarded as alignment.
    send_word(32'h3F, 6);
    rst_n = 1'b0;
    tick(1);
    check("midrst_data", {52'd0, data}, 64'd0);
    check("midrst_aligned", {63'd0, aligned}, 64'd0);
    check("midrst_pulses", {62'd0, data_valid, frame_err}, 64'd0);
    tick(1);
    rst_n = 1'b1;
    m_aligned = 1'b0;
    m_held    = '0;
    fbits.delete();
    tick(2);
    send_word(32'hABC, W);
    do_latch();
    check("post_rst_data_zero", {52'd0, data}, 64'd0);
    send_word(32'hFFF, W);
    do_latch();

    // Final CK rise and latch rise land in the same synchroniser cycle.
    send_word(32'h9B4 >> 1, W - 1);
    sr_q = 1'b0;
    tick(2);
    sr_ck    = 1'b1;
    sr_latch = 1'b1;
    fbits.push_back(1'b0);
    model_latch(cyc);
    tick(2);
    sr_ck    = 1'b0;
    sr_latch = 1'b0;
    tick(LAT + 4);
    check("data_same_cycle", {52'd0, data}, 64'h9B4);

`ifdef SR_DEGLITCH_EN
    // One-CLK glitch on SR_CK during a bit must not cause an extra shift.
    send_word(32'h1B, 5);
    sr_q = 1'b1;
    tick(1);
    sr_ck = 1'b1;
    tick(1);
    sr_ck = 1'b0;
    tick(2);
    sr_ck = 1'b1;
    fbits.push_back(1'b1);
    tick(2);
    sr_ck = 1'b0;
    send_word(32'h2D, 6);
    do_latch();
`endif

    // Randomised frames of good and bad lengths.
    for (int k = 0; k < 24; k++) begin
      int          sel;
      int          n;
      logic [31:0] v;
      sel = int'($urandom_range(0, 3));
      v   = $urandom;
      case (sel)
        0, 1:    n = W;
        2:       n = ($urandom_range(0, 1) != 0) ? W + 1 : W - 1;
        default: n = int'($urandom_range(0, W + 4));
      endcase
      send_word(v, n);
      do_latch();
    end

    tick(10);
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("final_data", {52'd0, data}, {52'd0, m_held});
    check("final_aligned", {63'd0, aligned}, 64'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
